// File: rtl/bnn_pkg.sv
// Shared types and defaults for the binary XNOR-popcount layer.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } bnn_state_e;

    localparam int N_IN_DEF  = 16;
    localparam int CHUNK_DEF = 4;
    localparam int N_NEU_DEF = 4;

    // Width needed to hold a count from 0 to n_bits inclusive.
    function automatic int cw_of(input int n_bits);
        return $clog2(n_bits + 1);
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count of a W-bit word.
module bnn_popcount #(
    parameter  int W  = 4,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [OW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/bnn_xnor_layer.sv
// Binary neural-network layer: N_NEU XNOR-popcount neurons over a chunked input vector.
//  state | meaning
//  IDLE  | ready for a vector; configuration writes accepted
//  ACCUM | one input chunk per cycle added into every accumulator
//  DONE  | thresholded result held until the consumer takes it
module bnn_xnor_layer
    import bnn_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEF,
    parameter  int CHUNK = CHUNK_DEF,
    parameter  int N_NEU = N_NEU_DEF,
    localparam int CW    = cw_of(N_IN),
    localparam int AW    = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic              cfg_is_th,
    input  logic [N_IN-1:0]   cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_NEU-1:0]  out_data
);

    localparam int NCH = N_IN / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(CHUNK + 1);

    bnn_state_e        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [N_NEU-1:0]  out_q, out_d;
    logic [CW-1:0]     acc_q   [N_NEU];
    logic [CW-1:0]     acc_d   [N_NEU];
    logic [CW-1:0]     acc_sum [N_NEU];
    logic [N_IN-1:0]   w_q     [N_NEU];
    logic [CW-1:0]     th_q    [N_NEU];
    logic [PW-1:0]     pc      [N_NEU];
    logic [N_IN-1:0]   x_sh;
    logic [CHUNK-1:0]  x_chunk;
    logic              cfg_ok;

    assign x_sh    = x_q >> (int'(k_q) * CHUNK);
    assign x_chunk = x_sh[CHUNK-1:0];

    for (genvar j = 0; j < N_NEU; j++) begin : g_neu
        logic [N_IN-1:0]  w_sh;
        logic [CHUNK-1:0] match;

        assign w_sh  = w_q[j] >> (int'(k_q) * CHUNK);
        assign match = ~(x_chunk ^ w_sh[CHUNK-1:0]);

        bnn_popcount #(.W(CHUNK)) u_pc (
            .bits_i  (match),
            .count_o (pc[j])
        );

        assign acc_sum[j] = acc_q[j] + CW'(pc[j]);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        out_d   = out_q;
        for (int j = 0; j < N_NEU; j++) acc_d[j] = acc_q[j];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    k_d     = '0;
                    state_d = ACCUM;
                    for (int j = 0; j < N_NEU; j++) acc_d[j] = '0;
                end
            end
            ACCUM: begin
                k_d = k_q + 1'b1;
                for (int j = 0; j < N_NEU; j++) acc_d[j] = acc_sum[j];
                if (k_q == KW'(NCH - 1)) begin
                    // Compare uses the sum including the final chunk.
                    k_d     = '0;
                    state_d = DONE;
                    for (int j = 0; j < N_NEU; j++) out_d[j] = (acc_sum[j] >= th_q[j]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            out_q   <= '0;
            for (int j = 0; j < N_NEU; j++) acc_q[j] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            out_q   <= out_d;
            for (int j = 0; j < N_NEU; j++) acc_q[j] <= acc_d[j];
        end
    end

    // Weights are only read in ACCUM, so an IDLE write lands before first use.
    assign cfg_ok = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < N_NEU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_NEU; j++) begin
                w_q[j]  <= '1;
                th_q[j] <= '0;
            end
        end else if (cfg_ok) begin
            if (cfg_is_th) th_q[cfg_addr] <= cfg_data[CW-1:0];
            else           w_q[cfg_addr]  <= cfg_data;
        end
    end

endmodule
